// File: rtl/ace_arb_pkg.sv
// Shared types and constants for the ACE line arbiter.
// ACE_ARB_TIMEOUT_EN enables the MEM_WAIT abort timer in the top level.
package ace_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_XFER   = 3'd1,
        WR_XFER   = 3'd2,
        MEM_WAIT  = 3'd3,
        SN_XFER   = 3'd4,
        SN_RESP   = 3'd5
    } arb_state_t;

    localparam logic SNOOP_CLEAN      = 1'b1;
    localparam logic SNOOP_INVALIDATE = 1'b0;

    localparam int TMO_CYCLES_DEFAULT = 16;
    localparam int TMO_CNT_W          = 8;

    // Round-robin pick encoding: bit 0 of the request vector is read.
    localparam logic RR_RD = 1'b0;
    localparam logic RR_WR = 1'b1;

endpackage

// File: rtl/ace_arb_rr.sv
// Two-way read/write round-robin pointer for the ACE line arbiter.
// pick is only meaningful while at least one request bit is set.
module ace_arb_rr
    import ace_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic       pick
);

    logic last;

    always_comb begin
        pick = last;
        if (req == 2'b11) begin
            pick = ~last;
        end else if (req[0]) begin
            pick = RR_RD;
        end else if (req[1]) begin
            pick = RR_WR;
        end
    end

    // Reset to "last = write" so the first tie goes to read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= RR_WR;
        end else if (adv) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/ace_line_arbiter.sv
// Arbitrates read, write and snoop access to one ACE cache line's state FSM.
// Define ACE_ARB_TIMEOUT_EN to abort MEM_WAIT after TMO_CYCLES cycles (pulses tmo_err).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a request; snoop first, then rd/wr round-robin
// RD_XFER   | one-cycle read grant, lf_arvalid to the line FSM
// WR_XFER   | one-cycle write grant, lf_awvalid to the line FSM
// MEM_WAIT  | line missed, waiting for mem_done (or timeout)
// SN_XFER   | one-cycle snoop grant, lf_acvalid/lf_acsnoop to the line FSM
// SN_RESP   | holding crvalid/cr_dirty until crready
module ace_line_arbiter
    import ace_arb_pkg::*;
#(
    parameter int TMO_CYCLES = TMO_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_req,
    input  logic wr_req,
    input  logic sn_req,
    input  logic sn_clean,
    output logic rd_gnt,
    output logic wr_gnt,
    output logic sn_gnt,
    output logic lf_arvalid,
    output logic lf_awvalid,
    output logic lf_acvalid,
    output logic lf_acsnoop,
    output logic lf_crready,
    input  logic invalid,
    input  logic unique_clean,
    input  logic unique_dirty,
    input  logic mem_done,
    output logic crvalid,
    output logic cr_dirty,
    input  logic crready,
    output logic busy,
    output logic tmo_err
);

    arb_state_t state, state_nxt;
    logic miss_q, miss_nxt;
    logic clean_q, clean_nxt;
    logic dirty_q, dirty_nxt;
    logic rr_pick;
    logic rr_adv;

    assign rr_adv = (state == IDLE) && !sn_req && (rd_req || wr_req);

    ace_arb_rr u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({wr_req, rd_req}),
        .adv   (rr_adv),
        .pick  (rr_pick)
    );

`ifdef ACE_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt;

    // Down-counter reloads outside MEM_WAIT; zero marks the last allowed wait cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != MEM_WAIT) begin
            tmo_cnt <= TMO_CNT_W'(TMO_CYCLES - 1);
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            miss_q  <= 1'b0;
            clean_q <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            miss_q  <= miss_nxt;
            clean_q <= clean_nxt;
            dirty_q <= dirty_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        miss_nxt   = miss_q;
        clean_nxt  = clean_q;
        dirty_nxt  = dirty_q;
        rd_gnt     = 1'b0;
        wr_gnt     = 1'b0;
        sn_gnt     = 1'b0;
        lf_arvalid = 1'b0;
        lf_awvalid = 1'b0;
        lf_acvalid = 1'b0;
        lf_acsnoop = SNOOP_INVALIDATE;
        lf_crready = 1'b0;
        crvalid    = 1'b0;
        cr_dirty   = 1'b0;
        tmo_err    = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (sn_req) begin
                    state_nxt = SN_XFER;
                    clean_nxt = sn_clean;
                    miss_nxt  = invalid;
                end else if (rd_req || wr_req) begin
                    state_nxt = (rr_pick == RR_WR) ? WR_XFER : RD_XFER;
                    miss_nxt  = invalid;
                end
            end
            RD_XFER: begin
                rd_gnt     = 1'b1;
                lf_arvalid = 1'b1;
                state_nxt  = miss_q ? MEM_WAIT : IDLE;
            end
            WR_XFER: begin
                wr_gnt     = 1'b1;
                lf_awvalid = 1'b1;
                state_nxt  = miss_q ? MEM_WAIT : IDLE;
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    state_nxt = IDLE;
                end
`ifdef ACE_ARB_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    tmo_err   = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            SN_XFER: begin
                sn_gnt     = 1'b1;
                lf_acvalid = 1'b1;
                lf_acsnoop = clean_q;
                // A line claiming both clean and dirty is reported clean.
                dirty_nxt  = unique_dirty & ~unique_clean;
                state_nxt  = SN_RESP;
            end
            SN_RESP: begin
                crvalid    = 1'b1;
                cr_dirty   = dirty_q;
                lf_crready = crready;
                if (crready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ace_line_arbiter.sv
// Self-checking bench for ace_line_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_ace_line_arbiter;

    localparam int TMO = 4;
`ifdef ACE_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rd_req = 1'b0, wr_req = 1'b0, sn_req = 1'b0, sn_clean = 1'b0;
    logic invalid = 1'b0, unique_clean = 1'b1, unique_dirty = 1'b0;
    logic mem_done = 1'b0, crready = 1'b0;
    logic rd_gnt, wr_gnt, sn_gnt, lf_arvalid, lf_awvalid, lf_acvalid, lf_acsnoop;
    logic lf_crready, crvalid, cr_dirty, busy, tmo_err;

    always #5 clk = ~clk;

    ace_line_arbiter #(.TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .wr_req(wr_req), .sn_req(sn_req), .sn_clean(sn_clean),
        .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .sn_gnt(sn_gnt),
        .lf_arvalid(lf_arvalid), .lf_awvalid(lf_awvalid), .lf_acvalid(lf_acvalid),
        .lf_acsnoop(lf_acsnoop), .lf_crready(lf_crready),
        .invalid(invalid), .unique_clean(unique_clean), .unique_dirty(unique_dirty),
        .mem_done(mem_done), .crvalid(crvalid), .cr_dirty(cr_dirty), .crready(crready),
        .busy(busy), .tmo_err(tmo_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_line(input int s);
        invalid      = (s == 0);
        unique_clean = (s == 1);
        unique_dirty = (s == 2);
    endtask

    // Transaction-level model: one transaction in flight, tracked by kind and age.
    // kind 0 = read, 1 = write, 2 = snoop; age 0 is the grant cycle.
    bit m_active = 1'b0;
    int m_kind = 0;
    int m_age = 0;
    bit m_miss = 1'b0, m_clean = 1'b0, m_dirty = 1'b0;
    bit m_last_wr = 1'b1;
    bit m_take_wr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  = 1'b0;
            m_kind    = 0;
            m_age     = 0;
            m_miss    = 1'b0;
            m_clean   = 1'b0;
            m_dirty   = 1'b0;
            m_last_wr = 1'b1;
        end else if (!m_active) begin
            if (sn_req) begin
                m_active = 1'b1; m_kind = 2; m_age = 0;
                m_clean = sn_clean; m_miss = invalid;
            end else if (rd_req || wr_req) begin
                m_take_wr = (rd_req && wr_req) ? !m_last_wr : wr_req;
                m_last_wr = m_take_wr;
                m_active = 1'b1; m_kind = m_take_wr ? 1 : 0; m_age = 0;
                m_miss = invalid;
            end
        end else if (m_age == 0) begin
            if (m_kind == 2) begin
                m_dirty = unique_dirty;
                m_age = 1;
            end else if (m_miss) begin
                m_age = 1;
            end else begin
                m_active = 1'b0;
            end
        end else if (m_kind == 2) begin
            if (crready) m_active = 1'b0;
            else m_age++;
        end else begin
            if (mem_done) m_active = 1'b0;
            else if (TMO_EN && m_age == TMO) m_active = 1'b0;
            else m_age++;
        end
    end

    logic [11:0] exp_v, act_v;
    logic e_grant, e_crv;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            e_grant = m_active && (m_age == 0);
            e_crv   = m_active && (m_kind == 2) && (m_age >= 1);
            exp_v = {e_grant && m_kind == 0, e_grant && m_kind == 1, e_grant && m_kind == 2,
                     e_grant && m_kind == 0, e_grant && m_kind == 1, e_grant && m_kind == 2,
                     e_grant && m_kind == 2 && m_clean, e_crv && crready,
                     e_crv, e_crv && m_dirty, m_active,
                     TMO_EN && m_active && m_kind != 2 && m_age == TMO && !mem_done};
            act_v = {rd_gnt, wr_gnt, sn_gnt, lf_arvalid, lf_awvalid, lf_acvalid,
                     lf_acsnoop, lf_crready, crvalid, cr_dirty, busy, tmo_err};
            chk("model_outputs", 32'(act_v), 32'(exp_v));
            chk("gnt_onehot", 32'($countones({rd_gnt, wr_gnt, sn_gnt}) <= 1), 32'd1);
            chk("lf_valid_onehot", 32'($countones({lf_arvalid, lf_awvalid, lf_acvalid}) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        rd_req = 0; wr_req = 0; sn_req = 0; sn_clean = 0;
        mem_done = 0; crready = 0;
        set_line(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int got[$];
    int pulses;
    int busy_cnt;
    int tmo_cnt_seen;

    initial begin
        // Hit read: grant for exactly one cycle, idle the cycle after.
        do_reset();
        chk("reset_busy", 32'(busy), 32'd0);
        rd_req = 1;
        @(negedge clk); rd_req = 0; #2;
        chk("hit_rd_gnt", 32'(rd_gnt), 32'd1);
        chk("hit_rd_arvalid", 32'(lf_arvalid), 32'd1);
        chk("hit_rd_busy", 32'(busy), 32'd1);
        @(negedge clk); #2;
        chk("hit_rd_gnt_off", 32'(rd_gnt), 32'd0);
        chk("hit_rd_idle", 32'(busy), 32'd0);

        // Miss write: grant, three MEM_WAIT cycles with mem_done in the third, then idle.
        do_reset();
        set_line(0); wr_req = 1;
        @(negedge clk); wr_req = 0; #2;
        chk("miss_wr_gnt", 32'(wr_gnt), 32'd1);
        chk("miss_wr_awvalid", 32'(lf_awvalid), 32'd1);
        @(negedge clk); #2; chk("miss_wr_wait1", 32'(busy), 32'd1);
        @(negedge clk); #2; chk("miss_wr_wait2", 32'(busy), 32'd1);
        @(negedge clk); mem_done = 1; #2;
        chk("miss_wr_wait3", 32'(busy), 32'd1);
        chk("miss_wr_no_tmo", 32'(tmo_err), 32'd0);
        @(negedge clk); mem_done = 0; #2;
        chk("miss_wr_idle", 32'(busy), 32'd0);

        // All three requesting after reset: sn, rd, wr, rd.
        do_reset();
        set_line(1); crready = 1; sn_clean = 1;
        rd_req = 1; wr_req = 1; sn_req = 1;
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            @(negedge clk); #2;
            if (sn_gnt) begin got.push_back(2); sn_req = 0; end
            else if (rd_gnt) got.push_back(0);
            else if (wr_gnt) got.push_back(1);
        end
        chk("order_count", 32'(got.size()), 32'd4);
        if (got.size() > 0) chk("order_0_sn", 32'(got[0]), 32'd2);
        if (got.size() > 1) chk("order_1_rd", 32'(got[1]), 32'd0);
        if (got.size() > 2) chk("order_2_wr", 32'(got[2]), 32'd1);
        if (got.size() > 3) chk("order_3_rd", 32'(got[3]), 32'd0);
        rd_req = 0; wr_req = 0;

        // Invalidating snoop on a dirty line, crready late by three cycles.
        do_reset();
        set_line(2); sn_clean = 0; crready = 0; sn_req = 1;
        pulses = 0;
        @(negedge clk); sn_req = 0; #2;
        chk("sn_gnt", 32'(sn_gnt), 32'd1);
        chk("sn_acvalid", 32'(lf_acvalid), 32'd1);
        chk("sn_acsnoop", 32'(lf_acsnoop), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) crready = 1;
            #2;
            chk("sn_crvalid_held", 32'(crvalid), 32'd1);
            chk("sn_cr_dirty_held", 32'(cr_dirty), 32'd1);
            pulses += int'(lf_crready);
        end
        @(negedge clk); crready = 0; #2;
        pulses += int'(lf_crready);
        chk("sn_crready_pulses", 32'(pulses), 32'd1);
        chk("sn_crvalid_off", 32'(crvalid), 32'd0);
        chk("sn_idle", 32'(busy), 32'd0);

        // Miss read with no mem_done: timeout when enabled, otherwise waits.
        do_reset();
        set_line(0); rd_req = 1;
        @(negedge clk); rd_req = 0; #2;
        chk("tmo_rd_gnt", 32'(rd_gnt), 32'd1);
        busy_cnt = 0; tmo_cnt_seen = 0;
`ifdef ACE_ARB_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk); #2;
            busy_cnt += int'(busy);
            if (k < TMO) tmo_cnt_seen += int'(tmo_err);
        end
        chk("tmo_wait_busy", 32'(busy_cnt), 32'(TMO));
        chk("tmo_no_early_err", 32'(tmo_cnt_seen), 32'd0);
        chk("tmo_err_pulse", 32'(tmo_err), 32'd1);
        @(negedge clk); #2;
        chk("tmo_idle_after", 32'(busy), 32'd0);
        chk("tmo_err_one_cycle", 32'(tmo_err), 32'd0);
`else
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #2;
            busy_cnt += int'(busy);
            tmo_cnt_seen += int'(tmo_err);
        end
        chk("notmo_stays_busy", 32'(busy_cnt), 32'd12);
        chk("notmo_no_err", 32'(tmo_cnt_seen), 32'd0);
        @(negedge clk); mem_done = 1;
        @(negedge clk); mem_done = 0; #2;
        chk("notmo_idle_after_done", 32'(busy), 32'd0);
`endif

        // Reset in the middle of MEM_WAIT.
        do_reset();
        set_line(0); rd_req = 1;
        @(negedge clk); rd_req = 0;
        @(negedge clk); #2;
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #1; rst_n = 0; rd_req = 1; set_line(1);
        #1;
        chk("rst_outputs_zero", 32'({rd_gnt, wr_gnt, sn_gnt, lf_arvalid, lf_awvalid, lf_acvalid,
                                     lf_acsnoop, lf_crready, crvalid, cr_dirty, busy, tmo_err}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        #4;
        chk("rst_no_gnt_first_edge", 32'(rd_gnt), 32'd0);
        @(negedge clk); rd_req = 0; #2;
        chk("rst_first_gnt", 32'(rd_gnt), 32'd1);
        @(negedge clk);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rd_gnt) rd_req = 0;
            else if (!rd_req) rd_req = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 31) == 0) rd_req = 0;
            if (wr_gnt) wr_req = 0;
            else if (!wr_req) wr_req = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 31) == 0) wr_req = 0;
            if (sn_gnt) sn_req = 0;
            else if (!sn_req) begin
                sn_req = ($urandom_range(0, 5) == 0);
                sn_clean = $urandom_range(0, 1);
            end
            set_line($urandom_range(0, 2));
            mem_done = ($urandom_range(0, 4) == 0);
            crready = ($urandom_range(0, 2) == 0);
            if (i % 700 == 350) begin
                #3 rst_n = 0;
                #4 rst_n = 1;
            end
        end
        rd_req = 0; wr_req = 0; sn_req = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/ace_line_arbiter.md
ACE_LINE_ARBITER -- requirements
Module: ace_line_arbiter

Interface
- REQ-001 SHALL have parameter TMO_CYCLES, default 16, memory-wait cycles before abort (range 2..255).
- REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
- REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have rd_req / wr_req / sn_req, input, 1 each, level requests held until granted.
- REQ-005 SHALL have sn_clean, input, 1, snoop type (1=clean, 0=invalidate), valid with sn_req.
- REQ-006 SHALL have rd_gnt / wr_gnt / sn_gnt, output, 1 each, one-cycle grant pulses.
- REQ-007 SHALL have lf_arvalid / lf_awvalid / lf_acvalid / lf_acsnoop / lf_crready, output, 1 each, commands to the line-state FSM.
- REQ-008 SHALL have invalid / unique_clean / unique_dirty, input, 1 each, line state from the FSM.
- REQ-009 SHALL have mem_done, input, 1, main-memory access complete.
- REQ-010 SHALL have crvalid / cr_dirty, output, 1 each, snoop response; crready, input, 1.
- REQ-011 SHALL have busy, output, 1, high in any state but IDLE; tmo_err, output, 1, abort pulse.

Function
- REQ-012 SHALL implement states IDLE, RD_XFER, WR_XFER, MEM_WAIT, SN_XFER, SN_RESP.
- REQ-013 SHALL in IDLE grant sn_req first; otherwise rd/wr round-robin: both pending -> requester not granted last; single pending -> that one.
- REQ-014 SHALL, on request sampled in IDLE at edge N, enter the XFER state at N+1 and drive the matching gnt and lf_*valid high for exactly that one cycle.
- REQ-015 SHALL latch miss = invalid at the granting edge; RD_XFER/WR_XFER go to MEM_WAIT if miss, else to IDLE (hit: IDLE at N+2).
- REQ-016 SHALL leave MEM_WAIT to IDLE on the edge sampling mem_done=1; mem_done outside MEM_WAIT is ignored.
- REQ-017 SHALL in SN_XFER drive lf_acsnoop = latched sn_clean with lf_acvalid, latch cr_dirty = unique_dirty, then enter SN_RESP.
- REQ-018 SHALL hold crvalid=1 and cr_dirty stable in SN_RESP until crready=1; lf_crready = crvalid & crready combinationally; IDLE next edge.
- REQ-019 SHALL not update the round-robin pointer on snoop grants; requests arriving while busy wait; a request dropped before grant is never granted.
- REQ-020 SHALL never assert more than one of rd_gnt, wr_gnt, sn_gnt, nor more than one lf_*valid, in any cycle.

Reset
- REQ-021 SHALL asynchronously force state IDLE, all outputs 0, miss 0, round-robin pointer "last = write" (read wins first tie), timeout counter 0.
- REQ-022 SHALL abort any in-flight transfer on reset with no completion or response emitted; first grant possible on the second edge after rst_n rises.

Configuration
- REQ-023 SHALL, with ACE_ARB_TIMEOUT_EN defined, count MEM_WAIT cycles; at TMO_CYCLES without mem_done pulse tmo_err one cycle and return to IDLE.
- REQ-024 SHALL, without ACE_ARB_TIMEOUT_EN, wait indefinitely in MEM_WAIT, tie tmo_err to 0, omit the counter.

Structure
- REQ-025 SHALL place the state enum, snoop-type constants and TMO_CYCLES default in package ace_arb_pkg.
- REQ-026 SHALL implement the two-way rd/wr pointer as sub-module ace_arb_rr (inputs req[1:0], adv; output pick).

Verification
- REQ-027 SHALL cover: line valid, rd_req=1 at edge 5 -> rd_gnt and lf_arvalid high cycle 6 only, busy low cycle 7.
- REQ-028 SHALL cover: invalid=1, wr_req at edge 5, mem_done at cycle 12 -> busy high 6..12, IDLE at 13.
- REQ-029 SHALL cover: rd_req=wr_req=sn_req=1 held after reset -> grant order sn, rd, wr, then rd again if held.
- REQ-030 SHALL cover: unique_dirty=1, sn_req with sn_clean=0, crready delayed 3 cycles -> lf_acvalid=1, lf_acsnoop=0 once; crvalid=cr_dirty=1 held 3 cycles; lf_crready one pulse.
- REQ-031 SHALL cover: macro on, TMO_CYCLES=4, miss read, no mem_done -> tmo_err pulse after 4 MEM_WAIT cycles, IDLE next; macro off -> stays busy.
- REQ-032 SHALL cover: rst_n low mid MEM_WAIT -> all outputs 0 immediately, no gnt for 1 edge after release.
